// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH FFT sequencer.
//   NumFftPoints : samples per FFT block (radix-3 x nine radix-2 stages)
//   NumFftStage  : butterfly stages in the FFT core
//   FftLatency   : sync_in -> sync_out latency of the FFT core, in cycles
//   BinW         : width of a bin / sample index
package prach_pkg;

  localparam int NumFftPoints = 1536;
  localparam int NumFftStage  = 10;
  localparam int FftLatency   = 1582;
  localparam int BinW         = 11;

  typedef enum logic [1:0] {IDLE, SKIP, FEED, DRAIN} prach_ctrl_state_t;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } iq_t;

  // 0 still runs one block; anything past the max is capped.
  function automatic logic [3:0] clamp_sym(input logic [3:0] n, input logic [3:0] max_sym);
    if (n == 4'd0)         return 4'd1;
    else if (n > max_sym)  return max_sym;
    else                   return n;
  endfunction

endpackage

// File: rtl/prach_fft_out_tag.sv
// Output-side tagger: registers FFT bins and labels them with bin/symbol index.
//   gate       : pass bins through (controller active)
//   clr        : reset counters for a new / aborted occasion
//   in_*       : FFT output bins, in_sync marks bin 0
//   dout_*     : registered bins with bin, symbol, sof, eof tags
//   blk_cnt    : full blocks emitted so far in this occasion
//   resync_err : sync seen mid-block (bins were lost)
module prach_fft_out_tag
  import prach_pkg::*;
#(
  parameter int FFT_LEN = NumFftPoints
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gate,
  input  logic              clr,
  input  logic [15:0]       in_dr,
  input  logic [15:0]       in_di,
  input  logic              in_dv,
  input  logic              in_sync,
  output logic [15:0]       dout_dr,
  output logic [15:0]       dout_di,
  output logic              dout_dv,
  output logic [BinW-1:0]   dout_bin,
  output logic [3:0]        dout_sym,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic [3:0]        blk_cnt,
  output logic              resync_err
);

  localparam logic [BinW-1:0] LAST_BIN = BinW'(FFT_LEN - 1);

  logic            vin;
  logic [BinW-1:0] nxt_bin, idx;
  iq_t             q;

  assign vin        = in_dv & gate;
  // sync always wins: a sync mid-block restarts the count at bin 0
  assign idx        = in_sync ? '0 : nxt_bin;
  assign resync_err = vin & in_sync & (nxt_bin != '0);
  assign dout_dr    = q.re;
  assign dout_di    = q.im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      dout_dv  <= 1'b0;
      dout_bin <= '0;
      dout_sym <= '0;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      nxt_bin  <= '0;
      blk_cnt  <= '0;
    end else if (clr) begin
      dout_dv  <= 1'b0;
      dout_bin <= '0;
      dout_sym <= '0;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      nxt_bin  <= '0;
      blk_cnt  <= '0;
    end else begin
      dout_dv  <= vin;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      if (vin) begin
        q        <= '{re: in_dr, im: in_di};
        dout_bin <= idx;
        dout_sym <= blk_cnt;
        dout_sof <= (idx == '0);
        dout_eof <= (idx == LAST_BIN);
        if (idx == LAST_BIN) begin
          nxt_bin <= '0;
          blk_cnt <= blk_cnt + 4'd1;  // symbol index of the next block
        end else begin
          nxt_bin <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prach_fft_ctrl.sv
// PRACH FFT sequencer: skips the CP, gates num_sym blocks of FFT_LEN samples
// into the FFT with sync_in, tags FFT output bins and signals completion.
//   cfg_*       : enable, CP length, symbols per occasion (latched on start)
//   start       : occasion-start strobe
//   din_*       : time-domain samples in
//   fft_din_*   : samples to FFT (1-cycle latency), fft_sync_in on block sample 0
//   fft_dout_*  : bins from FFT, fft_sync_out on bin 0
//   dout_*      : tagged bins out (1-cycle latency)
//   done/busy   : occasion complete pulse / controller active
//   err_overrun : sticky, start while busy or lost output bins
module prach_fft_ctrl
  import prach_pkg::*;
#(
  parameter int FFT_LEN = NumFftPoints,
  parameter int MAX_SYM = 12,
  parameter int CP_W    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [CP_W-1:0]   cfg_cp_len,
  input  logic [3:0]        cfg_num_sym,
  input  logic              start,
  input  logic [15:0]       din_dr,
  input  logic [15:0]       din_di,
  input  logic              din_dv,
  output logic [15:0]       fft_din_dr,
  output logic [15:0]       fft_din_di,
  output logic              fft_din_dv,
  output logic              fft_sync_in,
  input  logic [15:0]       fft_dout_dr,
  input  logic [15:0]       fft_dout_di,
  input  logic              fft_dout_dv,
  input  logic              fft_sync_out,
  output logic [15:0]       dout_dr,
  output logic [15:0]       dout_di,
  output logic              dout_dv,
  output logic [BinW-1:0]   dout_bin,
  output logic [3:0]        dout_sym,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic              done,
  output logic              busy,
  output logic              err_overrun
);

  localparam logic [BinW-1:0] LAST_SMP = BinW'(FFT_LEN - 1);

  prach_ctrl_state_t state_q, state_d;
  logic [CP_W-1:0]   cp_cnt;
  logic [BinW-1:0]   smp_cnt, smp_idx;
  logic [3:0]        in_sym, in_sym_idx, num_sym_q, blk_cnt;
  logic              start_acc, feed_dv, blk_last, done_d, resync_err, gate, clr;
  iq_t               fin_q;

  // a start coinciding with done is still the tail of the old occasion
  assign start_acc = start & cfg_en & (state_q == IDLE) & ~done;
  // with no CP the start-cycle sample is already FEED sample 0
  assign feed_dv   = din_dv & cfg_en &
                     ((state_q == FEED) | (start_acc & (cfg_cp_len == '0)));
  // counters are stale in IDLE; the start-cycle sample is index 0 of symbol 0
  assign smp_idx    = (state_q == IDLE) ? '0 : smp_cnt;
  assign in_sym_idx = (state_q == IDLE) ? '0 : in_sym;
  assign blk_last   = feed_dv & (smp_idx == LAST_SMP) & ((in_sym_idx + 4'd1) == num_sym_q);

  assign gate       = (state_q != IDLE) & cfg_en;
  assign clr        = start_acc | ~cfg_en;
  assign busy       = (state_q != IDLE);
  assign fft_din_dr = fin_q.re;
  assign fft_din_di = fin_q.im;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!cfg_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_acc)
                 state_d = (cfg_cp_len > CP_W'(din_dv)) ? SKIP : FEED;
        SKIP:  if (din_dv && cp_cnt == CP_W'(1)) state_d = FEED;
        FEED:  if (blk_last) state_d = DRAIN;
        DRAIN: if (blk_cnt == num_sym_q) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      fin_q       <= '0;
      fft_din_dv  <= 1'b0;
      fft_sync_in <= 1'b0;
      cp_cnt      <= '0;
      smp_cnt     <= '0;
      in_sym      <= '0;
      num_sym_q   <= '0;
    end else begin
      state_q     <= state_d;
      done        <= done_d;
      fin_q       <= '{re: din_dr, im: din_di};
      fft_din_dv  <= feed_dv;
      fft_sync_in <= feed_dv & (smp_idx == '0);
      err_overrun <= err_overrun | (start & (state_q != IDLE)) | resync_err;

      if (start_acc) begin
        num_sym_q <= clamp_sym(cfg_num_sym, 4'(MAX_SYM));
        cp_cnt    <= cfg_cp_len - CP_W'(din_dv);  // start-cycle sample counts as CP
        smp_cnt   <= '0;
        in_sym    <= '0;
      end else if (state_q == SKIP && din_dv) begin
        cp_cnt <= cp_cnt - CP_W'(1);
      end

      if (feed_dv) begin
        if (smp_idx == LAST_SMP) begin
          smp_cnt <= '0;
          in_sym  <= in_sym_idx + 4'd1;
        end else begin
          smp_cnt <= smp_idx + 1'b1;
          in_sym  <= in_sym_idx;
        end
      end
    end
  end

  prach_fft_out_tag #(.FFT_LEN(FFT_LEN)) u_out_tag (
    .clk        (clk),
    .rst_n      (rst_n),
    .gate       (gate),
    .clr        (clr),
    .in_dr      (fft_dout_dr),
    .in_di      (fft_dout_di),
    .in_dv      (fft_dout_dv),
    .in_sync    (fft_sync_out),
    .dout_dr    (dout_dr),
    .dout_di    (dout_di),
    .dout_dv    (dout_dv),
    .dout_bin   (dout_bin),
    .dout_sym   (dout_sym),
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof),
    .blk_cnt    (blk_cnt),
    .resync_err (resync_err)
  );

endmodule

// File: tb/tb_prach_fft_ctrl.sv
module tb_prach_fft_ctrl;

  localparam int LAT = 4;  // stand-in FFT: a short delay line

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_en = 1'b1, start = 1'b0, din_dv = 1'b0;
  logic [13:0] cfg_cp_len = '0;
  logic [3:0]  cfg_num_sym = 4'd1;
  logic [15:0] din_dr = '0, din_di = '0;
  logic [15:0] fft_din_dr, fft_din_di, fft_dout_dr, fft_dout_di, dout_dr, dout_di;
  logic        fft_din_dv, fft_sync_in, fft_dout_dv, fft_sync_out;
  logic        dout_dv, dout_sof, dout_eof, done, busy, err_overrun;
  logic [10:0] dout_bin;
  logic [3:0]  dout_sym;

  prach_fft_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_cp_len(cfg_cp_len),
    .cfg_num_sym(cfg_num_sym), .start(start),
    .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .fft_din_dr(fft_din_dr), .fft_din_di(fft_din_di), .fft_din_dv(fft_din_dv),
    .fft_sync_in(fft_sync_in),
    .fft_dout_dr(fft_dout_dr), .fft_dout_di(fft_dout_di), .fft_dout_dv(fft_dout_dv),
    .fft_sync_out(fft_sync_out),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .dout_bin(dout_bin),
    .dout_sym(dout_sym), .dout_sof(dout_sof), .dout_eof(dout_eof),
    .done(done), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // FFT model
  logic [LAT-1:0] p_dv = '0, p_sy = '0;
  logic [15:0]    p_dr [LAT];
  logic [15:0]    p_di [LAT];
  logic           inj = 1'b0;
  always @(posedge clk) begin
    p_dv  <= {p_dv[LAT-2:0], fft_din_dv};
    p_sy  <= {p_sy[LAT-2:0], fft_sync_in};
    p_dr[0] <= fft_din_dr;
    p_di[0] <= fft_din_di;
    for (int i = 1; i < LAT; i++) begin
      p_dr[i] <= p_dr[i-1];
      p_di[i] <= p_di[i-1];
    end
  end
  assign fft_dout_dv  = p_dv[LAT-1];
  assign fft_sync_out = p_sy[LAT-1] | inj;
  assign fft_dout_dr  = p_dr[LAT-1];
  assign fft_dout_di  = p_di[LAT-1];

  // monitors
  int cyc = 0;
  int checks = 0, failures = 0;
  int sidx = 0, t_in = -1;
  int cnt_fdv, n_sync, cnt_dv, cnt_done, n_sof, eof_bad, t_first, t_eof, t_done;
  int sync_dr [4];
  int sof_sym [4];
  int sof_dr  [4];
  bit inj_arm = 0;
  int inj_bin = -1, inj_sof = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fft_din_dv) begin
      cnt_fdv++;
      if (t_first < 0) t_first = cyc;
    end
    if (fft_sync_in) begin
      if (n_sync < 4) sync_dr[n_sync] = int'(fft_din_dr);
      n_sync++;
    end
    if (dout_dv) cnt_dv++;
    if (dout_sof && n_sof < 4) begin
      sof_sym[n_sof] = int'(dout_sym);
      sof_dr[n_sof]  = int'(dout_dr);
      n_sof++;
    end
    if (dout_eof) begin
      t_eof = cyc;
      if (dout_bin != 11'd1535) eof_bad++;
    end
    if (done) begin
      cnt_done++;
      t_done = cyc;
    end
    if (inj) begin
      inj_bin = int'(dout_bin);
      inj_sof = int'(dout_sof);
      inj = 1'b0;
    end else if (inj_arm && dout_dv && dout_bin == 11'd700) begin
      inj = 1'b1;
      inj_arm = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    @(negedge clk); #1;
    cnt_fdv = 0; n_sync = 0; cnt_dv = 0; cnt_done = 0; n_sof = 0; eof_bad = 0;
    t_first = -1; t_eof = -1; t_done = -1;
    for (int i = 0; i < 4; i++) begin sync_dr[i] = -1; sof_sym[i] = -1; sof_dr[i] = -1; end
    sidx = 0;
  endtask

  // one cycle of input; sample label = index of valid sample since start
  task automatic step(input bit dv, input bit st);
    @(posedge clk); #1;
    start  = st;
    din_dv = dv;
    din_dr = 16'(sidx);
    din_di = ~16'(sidx);
    if (dv) begin
      if (sidx == 3168) t_in = cyc;
      sidx++;
    end
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk); #1;
      if (done) got = 1;
    end
    chk(tag, int'(got), 1);
  endtask

  initial begin
    clr_cnt();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fdv", int'(fft_din_dv), 0);
    chk("rst_dv", int'(dout_dv), 0);
    chk("rst_err", int'(err_overrun), 0);
    rst_n = 1'b1;

    // T1: long CP, one symbol, continuous input
    cfg_cp_len = 14'd3168; cfg_num_sym = 4'd1;
    clr_cnt();
    step(1, 1);
    repeat (3168 + 1536 - 1) step(1, 0);
    step(0, 0);
    wait_done("t1_done_seen");
    chk("t1_first_lat", t_first - t_in, 1);
    chk("t1_sync_cnt", n_sync, 1);
    chk("t1_sync_smp", sync_dr[0], 3168);
    chk("t1_fdv_cnt", cnt_fdv, 1536);
    chk("t1_dv_cnt", cnt_dv, 1536);
    chk("t1_sof_data", sof_dr[0], 3168);
    chk("t1_eof_bin", eof_bad, 0);
    chk("t1_done_lat", t_done - t_eof, 1);
    repeat (3) @(negedge clk);
    chk("t1_done_cnt", cnt_done, 1);
    chk("t1_busy", int'(busy), 0);
    chk("t1_err", int'(err_overrun), 0);

    // T2: no CP, two symbols, 50% input duty
    cfg_cp_len = 14'd0; cfg_num_sym = 4'd2;
    clr_cnt();
    step(1, 1);
    while (sidx < 3072) begin step(0, 0); step(1, 0); end
    step(0, 0);
    wait_done("t2_done_seen");
    chk("t2_fdv_cnt", cnt_fdv, 3072);
    chk("t2_sync_cnt", n_sync, 2);
    chk("t2_sync0", sync_dr[0], 0);
    chk("t2_sync1", sync_dr[1], 1536);
    chk("t2_sof_cnt", n_sof, 2);
    chk("t2_sym0", sof_sym[0], 0);
    chk("t2_sym1", sof_sym[1], 1);
    chk("t2_eof_bin", eof_bad, 0);
    chk("t2_dv_cnt", cnt_dv, 3072);

    // T3: start re-pulsed mid-FEED
    cfg_cp_len = 14'd0; cfg_num_sym = 4'd1;
    clr_cnt();
    step(1, 1);
    repeat (699) step(1, 0);
    step(1, 1);
    repeat (835) step(1, 0);
    step(0, 0);
    wait_done("t3_done_seen");
    chk("t3_err", int'(err_overrun), 1);
    chk("t3_fdv_cnt", cnt_fdv, 1536);
    repeat (5) @(negedge clk);
    chk("t3_done_cnt", cnt_done, 1);
    chk("t3_err_sticky", int'(err_overrun), 1);

    // T6: async reset mid-FEED
    clr_cnt();
    step(1, 1);
    repeat (499) step(1, 0);
    @(negedge clk); #1;
    chk("t6_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_fdv", int'(fft_din_dv), 0);
    chk("t6_dv", int'(dout_dv), 0);
    chk("t6_bin", int'(dout_bin), 0);
    chk("t6_err", int'(err_overrun), 0);
    @(negedge clk); rst_n = 1'b1;
    clr_cnt();
    repeat (2000) step(1, 0);
    step(0, 0);
    chk("t6_post_fdv", cnt_fdv, 0);
    chk("t6_post_dv", cnt_dv, 0);
    chk("t6_post_busy", int'(busy), 0);

    // T4: injected sync at bin 700
    clr_cnt();
    inj_arm = 1;
    step(1, 1);
    repeat (1535) step(1, 0);
    step(0, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("t4_inj_bin", inj_bin, 0);
    chk("t4_inj_sof", inj_sof, 1);
    chk("t4_err", int'(err_overrun), 1);
    chk("t4_no_done", cnt_done, 0);
    chk("t4_busy", int'(busy), 1);
    cfg_en = 1'b0;
    @(posedge clk); #1;
    chk("t4_abort_busy", int'(busy), 0);
    cfg_en = 1'b1;

    // T5a: cfg_en dropped in SKIP
    cfg_cp_len = 14'd100; cfg_num_sym = 4'd1;
    clr_cnt();
    step(1, 1);
    repeat (49) step(1, 0);
    chk("t5_skip_busy", int'(busy), 1);
    cfg_en = 1'b0;
    @(posedge clk); #1;
    chk("t5_skip_abort", int'(busy), 0);
    cfg_en = 1'b1;
    repeat (300) step(1, 0);
    chk("t5_skip_fdv", cnt_fdv, 0);

    // T5b: cfg_en dropped in DRAIN
    cfg_cp_len = 14'd0;
    clr_cnt();
    step(1, 1);
    repeat (1535) step(1, 0);
    step(0, 0);
    chk("t5_drain_busy", int'(busy), 1);
    cfg_en = 1'b0;
    @(posedge clk); #1;
    chk("t5_drain_abort", int'(busy), 0);
    cnt_dv = 0; cnt_done = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_drain_dv", cnt_dv, 0);
    chk("t5_drain_done", cnt_done, 0);
    cfg_en = 1'b1;

    // T5c: fresh occasion, num_sym=0 runs one block
    cfg_cp_len = 14'd5; cfg_num_sym = 4'd0;
    clr_cnt();
    step(1, 1);
    repeat (5 + 1536 - 1) step(1, 0);
    step(0, 0);
    wait_done("t5_done_seen");
    chk("t5_fdv_cnt", cnt_fdv, 1536);
    chk("t5_sync_smp", sync_dr[0], 5);
    repeat (3) @(negedge clk);
    chk("t5_done_cnt", cnt_done, 1);
    chk("t5_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prach_fft_ctrl.md
Name: prach_fft_ctrl

Overview:
- Sequencer in front of and behind the 1536-point PRACH FFT (radix-3 stage followed by nine radix-2 DIT stages).
- Per PRACH occasion: discards the cyclic-prefix samples, then gates exactly NUM_SYM back-to-back blocks of 1536 valid samples into the FFT, each block marked with sync_in on its first sample.
- Tags FFT output bins with bin index and symbol index, and signals occasion completion.
- Sits between the time-domain decimation chain and the frequency-domain correlator.

Parameters:
- FFT_LEN, 1536: samples per FFT block; must equal the FFT size.
- MAX_SYM, 12: maximum symbols per occasion; sets width of the symbol counters.
- CP_W, 14: width of cfg_cp_len.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_en  in  1  controller enable; low aborts the occasion
- cfg_cp_len  in  CP_W  valid CP samples to discard; latched at start
- cfg_num_sym  in  4  FFT blocks per occasion, 1..MAX_SYM; latched at start
- start  in  1  single-cycle occasion-start strobe
- din_dr, din_di  in  16 each  time-domain I/Q
- din_dv  in  1  input sample valid
- fft_din_dr, fft_din_di  out  16 each  to FFT
- fft_din_dv  out  1  to FFT
- fft_sync_in  out  1  to FFT; first sample of a block
- fft_dout_dr, fft_dout_di  in  16 each  from FFT
- fft_dout_dv  in  1  from FFT
- fft_sync_out  in  1  from FFT; first bin of a block
- dout_dr, dout_di  out  16 each  frequency-domain I/Q
- dout_dv  out  1  output bin valid
- dout_bin  out  11  bin index 0..1535
- dout_sym  out  4  symbol index within the occasion
- dout_sof  out  1  bin 0 of any symbol
- dout_eof  out  1  bin 1535 of any symbol
- done  out  1  one-cycle pulse after the last bin of the last symbol
- busy  out  1  high when not IDLE
- err_overrun  out  1  sticky error flag; cleared only by rst_n

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Input path latency: 1 cycle. fft_din_* and fft_sync_in are registered copies of din_*, qualified by state.
- Only din_dv cycles advance the input counters. Gaps in din_dv are passed through as fft_din_dv=0.
- FSM states: IDLE, SKIP, FEED, DRAIN.
- IDLE:
  - On start with cfg_en=1: latch cfg_cp_len and cfg_num_sym; clamp num_sym 0 to 1 and values above MAX_SYM to MAX_SYM.
  - Go to SKIP if cp_len>0, else FEED.
  - The input sample on the start cycle is the first sample considered, counted as CP or as FEED sample 0.
- SKIP: count cp_len valid samples with fft_din_dv=0, then go to FEED.
- FEED:
  - Forward valid samples; sample counter runs 0..FFT_LEN-1.
  - fft_sync_in=1 together with fft_din_dv on sample 0 of each block.
  - At sample FFT_LEN-1: increment the input symbol counter. If it equals num_sym, go to DRAIN; otherwise stay in FEED with no gap.
- DRAIN: wait until the output side has emitted num_sym full blocks, then pulse done and return to IDLE.
- Output path latency: 1 cycle (registered).
  - fft_sync_out with fft_dout_dv sets dout_bin=0 and asserts dout_sof. Each subsequent valid bin increments dout_bin.
  - dout_eof asserts at bin FFT_LEN-1, then dout_sym increments.
  - Output bins arriving in IDLE are dropped: dout_dv=0, no counting.
- Simultaneous events:
  - start while not IDLE: ignored, err_overrun set.
  - start in the same cycle as done: ignored, no error.
  - fft_sync_out arriving while dout_bin is not 1535 (lost bins): err_overrun set, bin counter resyncs to 0.
- cfg_en low in any state: next cycle goes to IDLE. fft_din_dv is forced 0 immediately, output gating stops, no done pulse. In-flight FFT data is dropped.
- Configuration changes outside IDLE have no effect.

Decomposition:
- prach_pkg holds:
  - localparam NumFftPoints=1536
  - localparam NumFftStage=10
  - the FFT latency constant (1582)
  - typedef enum logic [1:0] {IDLE, SKIP, FEED, DRAIN} prach_ctrl_state_t
  - typedef for the 16-bit signed I/Q sample pair.
- One sub-module, prach_fft_out_tag: output bin/symbol counter, sof/eof generation, resync error. It takes a gate enable and a clear from the main FSM.

Test Plan:
- start, cp_len=3168, num_sym=1, continuous din_dv → first fft_din_dv (with fft_sync_in) 1 cycle after input sample 3168; exactly 1536 fft_din_dv; done pulse 1 cycle after dout_eof.
- cp_len=0, num_sym=2, din_dv at 50% duty → fft_sync_in on FEED samples 0 and 1536 only; 3072 forwarded samples; dout_sym 0 then 1; dout_bin wraps 1535→0.
- start re-pulsed mid-FEED → err_overrun=1 and stays 1; the occasion completes unaffected with one done.
- cfg_en dropped during SKIP and again during DRAIN → busy=0 next cycle, no done, no further dout_dv; a new start then works normally.
- Injected fft_sync_out at dout_bin=700 → err_overrun=1, dout_bin restarts at 0 with dout_sof.
- rst_n asserted mid-FEED → all outputs 0 asynchronously; after release, state is IDLE and samples are dropped until the next start.
